// File: rtl/z80_bus_router.sv
// z80_bus_router: routes single Z80 memory accesses to one of 2**RB address
// regions through a registered IDLE/WAIT/DONE access FSM with per-region
// wait states, optional external ready, write protection and ready timeout.
module z80_bus_router #(
    parameter int unsigned               ADDR_W   = 16,
    parameter int unsigned               DATA_W   = 8,
    parameter int unsigned               RB       = 2,
    parameter logic [(2**RB)-1:0]        MAP_MASK = 4'b0011,
    parameter logic [(2**RB)-1:0]        RO_MASK  = 4'b0001,
    parameter logic [(2**RB)-1:0]        EXT_MASK = 4'b0000,
    parameter logic [4*(2**RB)-1:0]      WAITS    = 16'h0000,
    parameter int unsigned               TIMEOUT  = 63,
    parameter logic [DATA_W-1:0]         FILL     = 8'hFF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_dout,
    input  logic                         cpu_wr,
    input  logic                         cpu_req,
    output logic [DATA_W-1:0]            cpu_din,
    output logic                         cpu_ready,
    output logic [(2**RB)-1:0]           reg_sel,
    output logic [ADDR_W-RB-1:0]         reg_addr,
    output logic [DATA_W-1:0]            reg_wdata,
    output logic [(2**RB)-1:0]           reg_wren,
    input  logic [(2**RB)*DATA_W-1:0]    reg_rdata,
    input  logic [(2**RB)-1:0]           reg_rdy,
    output logic                         wp_fault,
    output logic                         tmo_err,
    output logic [7:0]                   fault_cnt
);

    localparam int unsigned REGIONS = 2**RB;
    localparam int unsigned LADDR_W = ADDR_W - RB;
    localparam int unsigned WCNT_W  = 4;
    localparam int unsigned TCNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned FCNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q,     state_d;
    logic [RB-1:0]        region_q,    region_d;
    logic                 wr_q,        wr_d;
    logic [WCNT_W-1:0]    cnt_q,       cnt_d;
    logic [TCNT_W-1:0]    tcnt_q,      tcnt_d;
    logic [DATA_W-1:0]    cpu_din_q,   cpu_din_d;
    logic                 cpu_ready_q, cpu_ready_d;
    logic [REGIONS-1:0]   reg_sel_q,   reg_sel_d;
    logic [LADDR_W-1:0]   reg_addr_q,  reg_addr_d;
    logic [DATA_W-1:0]    reg_wdata_q, reg_wdata_d;
    logic [FCNT_W-1:0]    fault_cnt_q, fault_cnt_d;

    logic [RB-1:0]        region_in;
    logic [WCNT_W-1:0]    waits_in;
    logic [REGIONS-1:0]   sel_oh;
    logic                 rdy_ok;
    logic [DATA_W-1:0]    rdata_sel;
    logic [REGIONS-1:0]   wren_c;
    logic                 wp_c;
    logic                 tmo_c;

    // Decode of the incoming request and of the latched active region
    always_comb begin
        region_in = cpu_addr[ADDR_W-1 -: RB];
        waits_in  = WAITS[WCNT_W*int'(region_in) +: WCNT_W];
        sel_oh    = REGIONS'(1) << region_q;
        rdy_ok    = !EXT_MASK[region_q] || reg_rdy[region_q];
        rdata_sel = reg_rdata[DATA_W*int'(region_q) +: DATA_W];
    end

    // Access FSM next-state, datapath next values and strobes
    always_comb begin
        state_d     = state_q;
        region_d    = region_q;
        wr_d        = wr_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;
        cpu_din_d   = cpu_din_q;
        cpu_ready_d = 1'b0;
        reg_sel_d   = reg_sel_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        wren_c      = '0;
        wp_c        = 1'b0;
        tmo_c       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    region_d    = region_in;
                    wr_d        = cpu_wr;
                    reg_addr_d  = cpu_addr[LADDR_W-1:0];
                    reg_wdata_d = cpu_dout;
                    if (!MAP_MASK[region_in]) begin
                        state_d     = S_DONE;
                        cpu_din_d   = FILL;
                        cpu_ready_d = 1'b1;
                    end else if (cpu_wr && RO_MASK[region_in]) begin
                        state_d     = S_DONE;
                        wp_c        = 1'b1;
                        cpu_ready_d = 1'b1;
                    end else begin
                        state_d   = S_WAIT;
                        cnt_d     = waits_in;
                        tcnt_d    = '0;
                        reg_sel_d = REGIONS'(1) << region_in;
                    end
                end
            end

            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WCNT_W'(1);
                end else if (rdy_ok) begin
                    if (wr_q) begin
                        wren_c = sel_oh;
                    end else begin
                        cpu_din_d = rdata_sel;
                    end
                    state_d     = S_DONE;
                    reg_sel_d   = '0;
                    cpu_ready_d = 1'b1;
                end else if (tcnt_q == TCNT_W'(TIMEOUT)) begin
                    state_d     = S_DONE;
                    cpu_din_d   = FILL;
                    tmo_c       = 1'b1;
                    reg_sel_d   = '0;
                    cpu_ready_d = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            S_DONE: begin
                state_d   = S_IDLE;
                reg_sel_d = '0;
            end

            default: begin
                state_d   = S_IDLE;
                reg_sel_d = '0;
            end
        endcase
    end

    // Saturating count of protection and timeout events
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if ((wp_c || tmo_c) && (fault_cnt_q != {FCNT_W{1'b1}})) begin
            fault_cnt_d = fault_cnt_q + FCNT_W'(1);
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            region_q    <= '0;
            wr_q        <= 1'b0;
            cnt_q       <= '0;
            tcnt_q      <= '0;
            cpu_din_q   <= FILL;
            cpu_ready_q <= 1'b0;
            reg_sel_q   <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            region_q    <= region_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            tcnt_q      <= tcnt_d;
            cpu_din_q   <= cpu_din_d;
            cpu_ready_q <= cpu_ready_d;
            reg_sel_q   <= reg_sel_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    // Same-cycle strobes are suppressed while reset is asserted so an aborted
    // access never writes
    always_comb begin
        cpu_din   = cpu_din_q;
        cpu_ready = cpu_ready_q;
        reg_sel   = reg_sel_q;
        reg_addr  = reg_addr_q;
        reg_wdata = reg_wdata_q;
        reg_wren  = rst ? '0 : wren_c;
        wp_fault  = wp_c  && !rst;
        tmo_err   = tmo_c && !rst;
        fault_cnt = fault_cnt_q;
    end

endmodule
